// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with 1-cycle read latency.
// Optional macro RAM_ARB_RSP_REG_EN adds one register stage on the read response path.
module ram_port_arbiter #(
  parameter int wordCount = 128,
  parameter int wordWidth = 64,
  parameter int maskWidth = wordWidth / 8,
  localparam int AW = $clog2(wordCount)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqA_valid,
  output logic                 reqA_ready,
  input  logic                 reqA_wr,
  input  logic [AW-1:0]        reqA_addr,
  input  logic [maskWidth-1:0] reqA_mask,
  input  logic [wordWidth-1:0] reqA_wrData,
  input  logic                 reqB_valid,
  output logic                 reqB_ready,
  input  logic                 reqB_wr,
  input  logic [AW-1:0]        reqB_addr,
  input  logic [maskWidth-1:0] reqB_mask,
  input  logic [wordWidth-1:0] reqB_wrData,
  output logic                 rspA_valid,
  output logic [wordWidth-1:0] rspA_rdData,
  output logic                 rspB_valid,
  output logic [wordWidth-1:0] rspB_rdData,
  output logic                 ram_en,
  output logic                 ram_wr,
  output logic [AW-1:0]        ram_addr,
  output logic [maskWidth-1:0] ram_mask,
  output logic [wordWidth-1:0] ram_wrData,
  input  logic [wordWidth-1:0] ram_rdData,
  output logic [15:0]          conflictCount
);

  // lastGrant: 0 = A, 1 = B
  logic lastGrant;
  logic grantA;
  logic grantB;
  logic fire;
  logic vld_p1;
  logic owner_p1;

  function automatic logic [15:0] satInc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  always_comb begin
    grantA = ~reset & reqA_valid & (~reqB_valid | lastGrant);
    grantB = ~reset & reqB_valid & ~grantA;
    fire   = grantA | grantB;
  end

  assign reqA_ready = grantA;
  assign reqB_ready = grantB;

  // Stage p0: winner's request steered straight to the RAM
  always_comb begin
    ram_en     = 1'b0;
    ram_wr     = 1'b0;
    ram_addr   = '0;
    ram_mask   = '0;
    ram_wrData = '0;
    if (grantA) begin
      ram_en     = 1'b1;
      ram_wr     = reqA_wr;
      ram_addr   = reqA_addr;
      ram_mask   = reqA_mask;
      ram_wrData = reqA_wrData;
    end else if (grantB) begin
      ram_en     = 1'b1;
      ram_wr     = reqB_wr;
      ram_addr   = reqB_addr;
      ram_mask   = reqB_mask;
      ram_wrData = reqB_wrData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant     <= 1'b1;
      vld_p1        <= 1'b0;
      owner_p1      <= 1'b0;
      conflictCount <= '0;
    end else begin
      if (fire) lastGrant <= grantB;
      vld_p1   <= fire & ~ram_wr;
      owner_p1 <= grantB;
      if (reqA_valid & reqB_valid) conflictCount <= satInc(conflictCount);
    end
  end

`ifdef RAM_ARB_RSP_REG_EN
  logic                 vldA_p2;
  logic                 vldB_p2;
  logic [wordWidth-1:0] rdData_p2;

  // Stage p2: extra response register; data is unreset and gated by valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vldA_p2 <= 1'b0;
      vldB_p2 <= 1'b0;
    end else begin
      vldA_p2 <= vld_p1 & ~owner_p1;
      vldB_p2 <= vld_p1 & owner_p1;
    end
  end

  always_ff @(posedge clk) begin
    rdData_p2 <= ram_rdData;
  end

  always_comb begin
    rspA_valid  = vldA_p2;
    rspB_valid  = vldB_p2;
    rspA_rdData = vldA_p2 ? rdData_p2 : '0;
    rspB_rdData = vldB_p2 ? rdData_p2 : '0;
  end
`else
  // Stage p1: RAM read data returned directly to the owning port
  always_comb begin
    rspA_valid  = vld_p1 & ~owner_p1;
    rspB_valid  = vld_p1 & owner_p1;
    rspA_rdData = rspA_valid ? ram_rdData : '0;
    rspB_rdData = rspB_valid ? ram_rdData : '0;
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural byte-masked RAM attached.
module tb_ram_port_arbiter;

`ifdef RAM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        reqA_valid, reqA_ready, reqA_wr;
  logic [6:0]  reqA_addr;
  logic [7:0]  reqA_mask;
  logic [63:0] reqA_wrData;
  logic        reqB_valid, reqB_ready, reqB_wr;
  logic [6:0]  reqB_addr;
  logic [7:0]  reqB_mask;
  logic [63:0] reqB_wrData;
  logic        rspA_valid, rspB_valid;
  logic [63:0] rspA_rdData, rspB_rdData;
  logic        ram_en, ram_wr;
  logic [6:0]  ram_addr;
  logic [7:0]  ram_mask;
  logic [63:0] ram_wrData, ram_rdData;
  logic [15:0] conflictCount;

  int total = 0;
  int bad = 0;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .reqA_valid(reqA_valid), .reqA_ready(reqA_ready), .reqA_wr(reqA_wr),
    .reqA_addr(reqA_addr), .reqA_mask(reqA_mask), .reqA_wrData(reqA_wrData),
    .reqB_valid(reqB_valid), .reqB_ready(reqB_ready), .reqB_wr(reqB_wr),
    .reqB_addr(reqB_addr), .reqB_mask(reqB_mask), .reqB_wrData(reqB_wrData),
    .rspA_valid(rspA_valid), .rspA_rdData(rspA_rdData),
    .rspB_valid(rspB_valid), .rspB_rdData(rspB_rdData),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
    .ram_wrData(ram_wrData), .ram_rdData(ram_rdData),
    .conflictCount(conflictCount)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: masked writes, read data one cycle after enable
  logic [63:0] mem [128];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        for (int b = 0; b < 8; b++)
          if (ram_mask[b]) mem[ram_addr][b*8 +: 8] <= ram_wrData[b*8 +: 8];
      end else begin
        ram_rdData <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic       aV, bV, aWr, bWr;
    logic [6:0] aAddr, bAddr;
    logic       rdyA, rdyB, en, wr;
    logic [6:0] addr;
    logic [15:0] cc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    reqA_valid = 1'b0; reqA_wr = 1'b0; reqA_addr = '0; reqA_mask = '0; reqA_wrData = '0;
    reqB_valid = 1'b0; reqB_wr = 1'b0; reqB_addr = '0; reqB_mask = '0; reqB_wrData = '0;
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int pulses;
  int runA, runB, maxRunA, maxRunB;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 64'h0;
    mem[5] = 64'h0000_0000_0000_DEAD;
    mem[7] = 64'hAAAA_BBBB_CCCC_DDDD;
    ram_rdData = '0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rspA_valid", 64'(rspA_valid), 64'd0);
    chk("rst_rspB_valid", 64'(rspB_valid), 64'd0);
    chk("rst_conflict", 64'(conflictCount), 64'd0);
    reqA_valid = 1'b1;
    reqB_valid = 1'b1;
    #1;
    chk("rst_readyA_low", 64'(reqA_ready), 64'd0);
    chk("rst_readyB_low", 64'(reqB_ready), 64'd0);
    chk("rst_ram_en_low", 64'(ram_en), 64'd0);

    // Table-driven arbitration sequence, applied from a fresh reset
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd5, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd5, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 7'd2, 1'b0, 1'b1, 1'b1, 1'b0, 7'd2, 16'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 7'd2, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 16'd1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 7'd2, 1'b0, 1'b1, 1'b1, 1'b0, 7'd2, 16'd2};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd3};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 7'd1, 7'd3, 1'b0, 1'b1, 1'b1, 1'b1, 7'd3, 16'd3};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 7'd2, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 16'd3};
    doReset();
    for (int i = 0; i < 7; i++) begin
      reqA_valid = vecs[i].aV; reqA_wr = vecs[i].aWr; reqA_addr = vecs[i].aAddr;
      reqB_valid = vecs[i].bV; reqB_wr = vecs[i].bWr; reqB_addr = vecs[i].bAddr;
      reqB_mask = 8'hFF; reqB_wrData = 64'h0;
      #1;
      chk($sformatf("vec%0d_readyA", i), 64'(reqA_ready), 64'(vecs[i].rdyA));
      chk($sformatf("vec%0d_readyB", i), 64'(reqB_ready), 64'(vecs[i].rdyB));
      chk($sformatf("vec%0d_ram_en", i), 64'(ram_en), 64'(vecs[i].en));
      chk($sformatf("vec%0d_ram_wr", i), 64'(ram_wr), 64'(vecs[i].wr));
      chk($sformatf("vec%0d_ram_addr", i), 64'(ram_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_conflict", i), 64'(conflictCount), 64'(vecs[i].cc));
      step();
    end
    idle();

    // Single A read of the preloaded word
    doReset();
    reqA_valid = 1'b1; reqA_addr = 7'd5;
    #1;
    chk("rdA_ready", 64'(reqA_ready), 64'd1);
    chk("rdA_readyB", 64'(reqB_ready), 64'd0);
    step();
    idle();
    for (int k = 1; k <= LAT; k++) begin
      #1;
      chk($sformatf("rdA_rspA_valid_c%0d", k), 64'(rspA_valid), 64'(k == LAT));
      chk($sformatf("rdA_rspA_data_c%0d", k), rspA_rdData, (k == LAT) ? 64'hDEAD : 64'h0);
      chk($sformatf("rdA_rspB_valid_c%0d", k), 64'(rspB_valid), 64'd0);
      step();
    end
    #1;
    chk("rdA_rspA_one_pulse", 64'(rspA_valid), 64'd0);

    // Both requesters held from reset: A, B, A, B
    doReset();
    reqA_valid = 1'b1; reqB_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_readyA", k), 64'(reqA_ready), 64'((k % 2) == 0));
      chk($sformatf("rr%0d_readyB", k), 64'(reqB_ready), 64'((k % 2) == 1));
      step();
    end
    idle();
    #1;
    chk("rr_conflict4", 64'(conflictCount), 64'd4);

    // Masked write by A, then B reads the merged word
    doReset();
    pulses = 0;
    reqA_valid = 1'b1; reqA_wr = 1'b1; reqA_addr = 7'd7;
    reqA_mask = 8'h03; reqA_wrData = 64'h1234;
    #1;
    if (ram_en && ram_wr) pulses++;
    chk("wr_ram_mask", 64'(ram_mask), 64'h03);
    step();
    idle();
    reqB_valid = 1'b1; reqB_addr = 7'd7;
    #1;
    if (ram_en && ram_wr) pulses++;
    chk("wrB_read_ready", 64'(reqB_ready), 64'd1);
    step();
    idle();
    for (int k = 1; k <= LAT; k++) begin
      #1;
      if (ram_en && ram_wr) pulses++;
      if (k < LAT) step();
    end
    chk("wr_pulse_count", 64'(pulses), 64'd1);
    chk("wr_rspB_valid", 64'(rspB_valid), 64'd1);
    chk("wr_rspB_data", rspB_rdData, 64'hAAAA_BBBB_CCCC_1234);
    chk("wr_rspA_quiet", 64'(rspA_valid), 64'd0);
    step();

    // Reset right after a read fire drops the response
    doReset();
    reqA_valid = 1'b1; reqB_valid = 1'b1; reqA_addr = 7'd5;
    step();
    reqB_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    reqA_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst31_rspA_c%0d", k), 64'(rspA_valid), 64'd0);
      chk($sformatf("rst31_rspB_c%0d", k), 64'(rspB_valid), 64'd0);
    end
    reqA_valid = 1'b1;
    #1;
    chk("rst31_readyA_low", 64'(reqA_ready), 64'd0);
    reset = 1'b0;
    reqB_valid = 1'b1;
    #1;
    chk("rst31_conflict", 64'(conflictCount), 64'd0);
    chk("rst31_A_wins_tie", 64'(reqA_ready), 64'd1);
    step();
    idle();

    // Long contention: saturation and starvation bound
    doReset();
    reqA_valid = 1'b1; reqB_valid = 1'b1;
    runA = 0; runB = 0; maxRunA = 0; maxRunB = 0;
    for (int k = 0; k < 70000; k++) begin
      #1;
      if (reqA_ready) runA = 0; else runA++;
      if (reqB_ready) runB = 0; else runB++;
      if (runA > maxRunA) maxRunA = runA;
      if (runB > maxRunB) maxRunB = runB;
      step();
    end
    idle();
    #1;
    chk("sat_conflict", 64'(conflictCount), 64'hFFFF);
    chk("starve_A_within_2", 64'(maxRunA < 2), 64'd1);
    chk("starve_B_within_2", 64'(maxRunB < 2), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter wordCount, default 128: RAM depth in words.
REQ-002 SHALL have parameter wordWidth, default 64: data width in bits.
REQ-003 SHALL have parameter maskWidth, default wordWidth/8: byte-mask width.
REQ-004 SHALL derive AW = $clog2(wordCount) as the address width.
REQ-005 SHALL have ports `clk` (in, 1: single clock) and `reset` (in, 1: asynchronous, active-high reset).
REQ-006 SHALL have, for X in {A, B}, the request ports:
- reqX_valid (in, 1): request present
- reqX_ready (out, 1): request accepted this cycle
- reqX_wr (in, 1): 1 = write, 0 = read
- reqX_addr (in, AW): word address
- reqX_mask (in, maskWidth): byte enables for writes
- reqX_wrData (in, wordWidth): write data
REQ-007 SHALL have, for X in {A, B}, the response ports rspX_valid (out, 1: read data valid) and rspX_rdData (out, wordWidth: read data).
REQ-008 SHALL have RAM-side ports:
- ram_en, ram_wr (out, 1)
- ram_addr (out, AW)
- ram_mask (out, maskWidth)
- ram_wrData (out, wordWidth)
- ram_rdData (in, wordWidth): valid one cycle after a read enable
REQ-009 SHALL have output conflictCount (out, 16): count of contention cycles.

Function
REQ-010 SHALL grant at most one requester per cycle; a transfer fires when reqX_valid & reqX_ready.
REQ-011 SHALL drive reqX_ready combinationally and never assert it without reqX_valid.
REQ-012 SHALL arbitrate round-robin using a 1-bit lastGrant register:
- only one valid: grant it
- both valid: grant the one not equal to lastGrant
REQ-013 SHALL update lastGrant to the granted port on every fire and hold it otherwise.
REQ-014 SHALL drive ram_en = 1 only in a firing cycle, with ram_wr, ram_addr, ram_mask and ram_wrData taken combinationally from the winner; non-enable cycles drive zeros.
REQ-015 SHALL register, on each read fire, a pending flag and an owner tag.
REQ-016 SHALL, in the following cycle, assert rspOwner_valid for exactly one cycle with rspOwner_rdData = ram_rdData.
REQ-017 SHALL give writes no response.
REQ-018 SHALL accept a new request every cycle (full throughput); back-to-back reads from alternating ports return in issue order.
REQ-019 SHALL have no response backpressure; a requester always accepts its response.
REQ-020 SHALL require requesters to hold valid, wr, addr, mask and wrData stable until ready; the arbiter does not latch requests.
REQ-021 SHALL bound starvation: a requester held valid SHALL be granted within 2 cycles.
REQ-022 SHALL increment conflictCount in each cycle where reqA_valid & reqB_valid, saturating at 0xFFFF.
REQ-023 SHALL drive rspX_rdData to zero whenever rspX_valid = 0.

Reset
REQ-024 SHALL, on reset assertion, immediately and asynchronously:
- clear the pending flag, so a read in flight is dropped with no response
- clear conflictCount
- set lastGrant = B, so A wins the first tie
- drive rspA_valid and rspB_valid to 0
REQ-025 SHALL keep reqX_ready low while reset is asserted.
REQ-026 SHALL resume arbitration in the first clk edge after reset deasserts.

Configuration
REQ-027 SHALL support macro RAM_ARB_RSP_REG_EN:
- defined: rspX_valid and rspX_rdData pass through one extra register stage, giving read latency = 2 cycles from fire; REQ-018 still holds.
- undefined: latency = 1 cycle, as in REQ-016.

Verification
REQ-028 A only, read addr 0x05 with RAM word 0x05 = 0xDEAD -> reqA_ready = 1 the same cycle; rspA_valid = 1 with 0xDEAD one cycle later (two cycles with RAM_ARB_RSP_REG_EN); rspB_valid stays 0.
REQ-029 A and B held valid for 4 cycles right after reset -> grants A, B, A, B; conflictCount = 4.
REQ-030 A writes 0x1234 with mask 0x03 to addr 7, then B reads addr 7 -> ram_en/ram_wr pulse once; rspB_rdData shows the new low two bytes and old upper bytes.
REQ-031 reset asserted in the cycle after an A read fire -> no rspA_valid pulse; lastGrant = B; conflictCount = 0.
REQ-032 both valid for 70000 cycles -> conflictCount saturates at 0xFFFF; neither port waits more than 2 cycles between grants.
